// File: rtl/ttbitcoin_pkg.sv
// Shared header geometry and read-FSM encoding for the work header responder.
package ttbitcoin_pkg;

    localparam int HDR_BYTES   = 80;
    localparam int HDR_WORDS   = 20;
    localparam int NONCE_WORD  = 19;
    localparam int NONCE_BYTE0 = 76;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

    // Word 19 is served in SHA stream order, i.e. the LE nonce byte-reversed.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/header_nonce_counter.sv
// 32-bit little-endian nonce with host byte-write port, +1 increment and wrap pulse.
// Updates on the clock edge; a byte write in the same cycle as an increment wins and drops the increment.
module header_nonce_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_wr_en,
    input  logic [1:0]  byte_sel,
    input  logic [7:0]  byte_dat,
    input  logic        inc,
    output logic [31:0] nonce,
    output logic        wrap
);

    logic [31:0] nonce_q, nonce_d;
    logic        wrap_q, wrap_d;

    always_comb begin
        nonce_d = nonce_q;
        wrap_d  = 1'b0;
        if (byte_wr_en) begin
            case (byte_sel)
                2'd0:    nonce_d[7:0]   = byte_dat;
                2'd1:    nonce_d[15:8]  = byte_dat;
                2'd2:    nonce_d[23:16] = byte_dat;
                default: nonce_d[31:24] = byte_dat;
            endcase
        end else if (inc) begin
            nonce_d = nonce_q + 32'd1;
            wrap_d  = (nonce_q == 32'hFFFF_FFFF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            nonce_q <= nonce_d;
            wrap_q  <= wrap_d;
        end
    end

    assign nonce = nonce_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/work_header_responder.sv
// Serves the 80-byte block header as 32-bit words; rdy pulses one cycle after rq is sampled.
// One outstanding request, one word per two cycles; rq is ignored while the response is on the bus.
module work_header_responder
    import ttbitcoin_pkg::*;
#(
    parameter int HDR_WORDS  = ttbitcoin_pkg::HDR_WORDS,
    parameter int NONCE_WORD = ttbitcoin_pkg::NONCE_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rq,
    input  logic [4:0]  addr,
    output logic [31:0] data,
    output logic        rdy,
    input  logic        wr_en,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        nonce_inc,
    output logic [31:0] nonce,
    output logic        nonce_wrap
);

    localparam int STORE_BYTES = NONCE_WORD * 4;

    logic [7:0]  hdr_q [0:STORE_BYTES-1];
    rd_state_e   state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rd_word;
    logic        store_wr;
    logic        nonce_wr;

    assign store_wr = wr_en && (int'(wr_addr) < STORE_BYTES);
    assign nonce_wr = wr_en && (int'(wr_addr) >= NONCE_BYTE0) && (int'(wr_addr) < HDR_BYTES);

    header_nonce_counter u_nonce (
        .clk        (clk),
        .rst        (rst),
        .byte_wr_en (nonce_wr),
        .byte_sel   (wr_addr[1:0]),
        .byte_dat   (wr_data),
        .inc        (nonce_inc),
        .nonce      (nonce),
        .wrap       (nonce_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STORE_BYTES; i++) begin
                hdr_q[i] <= '0;
            end
        end else if (store_wr) begin
            hdr_q[wr_addr] <= wr_data;
        end
    end

    // Reads see pre-edge storage, so a same-cycle write or increment returns the old word.
    always_comb begin
        rd_word = '0;
        if (int'(addr) >= HDR_WORDS) begin
            rd_word = '0;
        end else if (int'(addr) == NONCE_WORD) begin
            rd_word = bswap32(nonce);
        end else begin
            rd_word = {hdr_q[{addr, 2'd0}], hdr_q[{addr, 2'd1}],
                       hdr_q[{addr, 2'd2}], hdr_q[{addr, 2'd3}]};
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (rq) begin
                    data_d  = rd_word;
                    state_d = RESP;
                end
            end
            RESP: begin
                data_d  = '0;
                state_d = IDLE;
            end
            default: begin
                data_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Gating with rst lets a reset during the response cycle suppress the pulse.
    always_comb begin
        rdy  = (state_q == RESP) && !rst;
        data = rdy ? data_q : '0;
    end

endmodule
